dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the memory stage of the pipelined MIPS core. Holds the word array, models a configurable access latency, and drives the global pipeline stall (the core's `AnyStall` input) until each access completes. It is the memory-side end of the ME-stage request interface: ME issues, this block answers.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait cycles between request acceptance and response; ≥ 0.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `req_val` in 1: ME stage holds a valid access (`InstrVal_EX` & (`MemWrite_EX` | `MemToReg_EX`)).
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address; ALU result from EX.
- `req_wdata` in 32: store data.
- `stall` out 1: pipeline stall request; drives `AnyStall`.
- `rsp_val` out 1: one-cycle pulse; access complete.
- `rsp_rdata` out 32: load data, valid while `rsp_val` = 1.
- `addr_err` out 1: pulses with `rsp_val` when `req_addr[1:0]` ≠ 0.
- `acc_count` out 32: count of completed accesses, wraps at 2^32.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: `stall` = `req_val` (combinational, so ME freezes in the same cycle). On `req_val`, capture `req_we`/`req_addr`/`req_wdata` and the 2-bit alignment check. With `LATENCY` = 0 go to DONE; otherwise load `cnt` = `LATENCY`−1 and go to WAIT.
- WAIT: `stall` = 1. If `cnt` = 0 go to DONE, else decrement `cnt`.
- DONE: `stall` = 0, `rsp_val` = 1, `addr_err` is the captured check, `acc_count` increments on this edge. `req_val` is ignored, because the same instruction is still on the inputs. The next state is always IDLE.
- Array access happens on the edge entering DONE:
  - Store writes `req_wdata` to the captured word.
  - Load registers the captured word into `rsp_rdata`.
  - For a store, `rsp_rdata` = 0.
- Word index = captured `addr[2 +: log2(DEPTH_WORDS)]`. Upper bits are ignored, so addresses alias and wrap modulo `DEPTH_WORDS`×4. `addr[1:0]` is ignored for the access (word-aligned) and only reported via `addr_err`.
- Inputs are sampled only in IDLE. Changes or a drop of `req_val` during WAIT/DONE are ignored; the captured access completes.
- Array contents are not reset and are undefined at power-up.

## Timing
- Request seen in IDLE at cycle 0:
  - `stall` is high for cycles 0 … `LATENCY`.
  - `rsp_val` and `rsp_rdata` are valid in cycle `LATENCY`+1.
  - The pipeline advances on the edge ending that cycle.
- Back-to-back accesses: the next request is seen in IDLE in cycle `LATENCY`+2. There are no extra bubbles beyond the DONE cycle.
- Read-after-write: a load following a store to the same word returns the new data.
- Reset values: state IDLE, `stall` 0 (combinational from `req_val` in IDLE, so effectively 0 while `reset` holds), `rsp_val` 0, `rsp_rdata` 0, `addr_err` 0, `acc_count` 0, `cnt` 0.
- Reset mid-operation (WAIT or DONE-entry): the access is aborted. A pending store is not written and `acc_count` is not incremented.
- `reset` takes priority over every transition.

## Structure
- Shared core package (`mips_pkg`): the `dmem_state_t` enum (IDLE/WAIT/DONE) and the default `DMEM_LATENCY` constant.
- Sub-module `dmem_array`: single-port synchronous RAM (registered read, write-enable), parameterised by `DEPTH_WORDS`.
- FSM, counter, capture registers and `acc_count` live in `dmem_responder`.

## Test plan
- Reset, `LATENCY`=2: hold `reset` for 2 cycles with `req_val`=0 → `stall`=0, `rsp_val`=0, `rsp_rdata`=0, `acc_count`=0.
- Store then load, `LATENCY`=2:
  - Store 0xDEADBEEF @0x40 → `stall` high for cycles 0–2, `rsp_val` in cycle 3.
  - Load @0x40 → `rsp_rdata`=0xDEADBEEF; `acc_count`=2.
- Back-to-back with `LATENCY`=0: two loads on consecutive IDLE opportunities → `stall` pattern 1,0,1,0; `rsp_val` pattern 0,1,0,1.
- Wrap, `DEPTH_WORDS`=256: store 0x12345678 @0x400, then load @0x000 → 0x12345678.
- Reset mid-WAIT:
  - Preload 0xAAAA0000 @0x8.
  - Start store 0x11 @0x8; assert `reset` in WAIT.
  - Load @0x8 → 0xAAAA0000; `acc_count`=0 after reset.
- Misaligned: load @0x42 → `addr_err`=1 with `rsp_val`, data from word @0x40; aligned loads → `addr_err`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core's data-memory responder.
package mips_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Default access latency (wait cycles between acceptance and response).
  localparam int DMEM_LATENCY = 2;

  // Width of the wait counter, which holds values 0 .. lat-1.
  // Never narrower than one bit, so LATENCY 0 and 1 still elaborate.
  function automatic int dmemCntWidth(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM with registered read.
// A write returns zero on the read port so a store never reports stale data.
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage: written only on an enabled store; contents are never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, loaded on an enabled load, zeroed on a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? 32'h0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the ME stage.
// Freezes the pipeline via stall while an access is in flight, performs the
// array access on the edge entering DONE and pulses rsp_val for one cycle.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_val,
  output logic [31:0] rsp_rdata,
  output logic        addr_err,
  output logic [31:0] acc_count
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = dmemCntWidth(LATENCY);

  dmem_state_t state;
  dmem_state_t nextState;

  logic [CNT_W-1:0] cnt;
  logic             capWe;
  logic             capErr;
  logic [AW-1:0]    capIdx;
  logic [31:0]      capWdata;
  logic [31:0]      accCount;

  logic             ramEn;
  logic             ramWe;
  logic [AW-1:0]    ramIdx;
  logic [31:0]      ramWdata;
  logic [31:0]      ramRdata;

  // Address bits above the word index only alias; they select nothing.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[31:AW+2];

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. Stall in IDLE follows req_val
  // combinationally so ME freezes in the very cycle it issues.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    rsp_val   = 1'b0;
    addr_err  = 1'b0;
    case (state)
      IDLE: begin
        stall = req_val;
        if (req_val) begin
          nextState = (LATENCY == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == '0) begin
          nextState = DONE;
        end
      end
      DONE: begin
        rsp_val   = 1'b1;
        addr_err  = capErr;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Wait counter and control-side capture (type of access, alignment flag).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      capWe  <= 1'b0;
      capErr <= 1'b0;
    end else if (state == IDLE && req_val) begin
      capWe  <= req_we;
      capErr <= (req_addr[1:0] != 2'b00);
      if (LATENCY > 0) begin
        cnt <= CNT_W'(LATENCY - 1);
      end
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Data-side capture; inputs are only sampled while IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_val) begin
      capIdx   <= req_addr[2 +: AW];
      capWdata <= req_wdata;
    end
  end

  // Completed-access counter; advances on the edge that ends DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      accCount <= '0;
    end else if (state == DONE) begin
      accCount <= accCount + 32'd1;
    end
  end

  // Array port: the access fires on the edge entering DONE. Leaving IDLE
  // straight to DONE (zero latency) the capture registers are not loaded
  // yet, so the live request feeds the array directly.
  always_comb begin
    ramEn    = (nextState == DONE) && (state != DONE) && !reset;
    ramWe    = capWe;
    ramIdx   = capIdx;
    ramWdata = capWdata;
    if (state == IDLE) begin
      ramWe    = req_we;
      ramIdx   = req_addr[2 +: AW];
      ramWdata = req_wdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .en   (ramEn),
    .we   (ramWe),
    .idx  (ramIdx),
    .wdata(ramWdata),
    .rdata(ramRdata)
  );

  assign rsp_rdata = ramRdata;
  assign acc_count = accCount;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized bench for dmem_responder.
// Instance 0 runs with LATENCY=2, instance 1 with LATENCY=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqVal   [2];
  logic        reqWe    [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic        stall    [2];
  logic        rspVal   [2];
  logic [31:0] rspRdata [2];
  logic        addrErr  [2];
  logic [31:0] accCount [2];

  int tests  = 0;
  int failed = 0;

  // Reference model: word memory per instance, known-word flags, access counts.
  logic [31:0] modelMem   [2][256];
  bit          modelKnown [2][256];
  logic [31:0] modelCount [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dutLat2 (
    .clk(clk), .reset(reset),
    .req_val(reqVal[0]), .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .stall(stall[0]), .rsp_val(rspVal[0]), .rsp_rdata(rspRdata[0]),
    .addr_err(addrErr[0]), .acc_count(accCount[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dutLat0 (
    .clk(clk), .reset(reset),
    .req_val(reqVal[1]), .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .stall(stall[1]), .rsp_val(rspVal[1]), .rsp_rdata(rspRdata[1]),
    .addr_err(addrErr[1]), .acc_count(accCount[1])
  );

  function automatic int latOf(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles: both instances quiet, counts match the model.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check32($sformatf("idle_stall[%0d]", s), 32'(stall[s]), 32'd0);
        check32($sformatf("idle_rsp_val[%0d]", s), 32'(rspVal[s]), 32'd0);
        check32($sformatf("idle_acc_count[%0d]", s), accCount[s], modelCount[s]);
      end
      @(posedge clk); #1;
    end
  endtask

  // One access, entered at the start of a cycle with the instance in IDLE.
  // stall must be high for cycles 0..lat, rsp_val high only in cycle lat+1.
  // With scramble set, inputs are perturbed after acceptance and must be ignored.
  task automatic access(input int sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit scramble);
    int          lat;
    int unsigned idx;
    logic [31:0] expData;
    bit          known;
    lat     = latOf(sel);
    idx     = (addr / 4) % 256;
    expData = we ? 32'h0 : modelMem[sel][idx];
    known   = we || modelKnown[sel][idx];
    reqVal[sel]   = 1'b1;
    reqWe[sel]    = we;
    reqAddr[sel]  = addr;
    reqWdata[sel] = wdata;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check32($sformatf("acc_count_pre[%0d]", sel), accCount[sel], modelCount[sel]);
      end
      check32($sformatf("stall[%0d]@%0d", sel, k), 32'(stall[sel]), (k <= lat) ? 32'd1 : 32'd0);
      check32($sformatf("rsp_val[%0d]@%0d", sel, k), 32'(rspVal[sel]), (k == lat + 1) ? 32'd1 : 32'd0);
      if (k == lat + 1) begin
        check32($sformatf("addr_err[%0d] a=%h", sel, addr), 32'(addrErr[sel]),
                (addr % 4 != 0) ? 32'd1 : 32'd0);
        if (known) begin
          check32($sformatf("rsp_rdata[%0d] a=%h we=%0d", sel, addr, we), rspRdata[sel], expData);
        end
      end
      @(posedge clk); #1;
      if (scramble && k < lat + 1) begin
        reqVal[sel]   = 1'($urandom);
        reqWe[sel]    = 1'($urandom);
        reqAddr[sel]  = $urandom;
        reqWdata[sel] = $urandom;
      end
    end
    reqVal[sel] = 1'b0;
    if (we) begin
      modelMem[sel][idx]   = wdata;
      modelKnown[sel][idx] = 1'b1;
    end
    modelCount[sel] = modelCount[sel] + 32'd1;
  endtask

  // Start a store and reset after cyclesBeforeReset edges; the store must vanish.
  task automatic abortStore(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                            input int cyclesBeforeReset);
    reqVal[sel]   = 1'b1;
    reqWe[sel]    = 1'b1;
    reqAddr[sel]  = addr;
    reqWdata[sel] = wdata;
    repeat (cyclesBeforeReset) begin
      @(posedge clk); #1;
    end
    reset       = 1'b1;
    reqVal[sel] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    modelCount[0] = 32'd0;
    modelCount[1] = 32'd0;
    @(negedge clk);
    check32($sformatf("abort_stall[%0d]", sel), 32'(stall[sel]), 32'd0);
    check32($sformatf("abort_rsp_val[%0d]", sel), 32'(rspVal[sel]), 32'd0);
    check32($sformatf("abort_rdata[%0d]", sel), rspRdata[sel], 32'd0);
    check32($sformatf("abort_acc_count[%0d]", sel), accCount[sel], 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rAddr;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      reqVal[s]     = 1'b0;
      reqWe[s]      = 1'b0;
      reqAddr[s]    = 32'h0;
      reqWdata[s]   = 32'h0;
      modelCount[s] = 32'd0;
      for (int w = 0; w < 256; w++) begin
        modelKnown[s][w] = 1'b0;
      end
    end

    // Reset held for two cycles with no request.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check32($sformatf("reset_stall[%0d]", s), 32'(stall[s]), 32'd0);
      check32($sformatf("reset_rsp_val[%0d]", s), 32'(rspVal[s]), 32'd0);
      check32($sformatf("reset_rdata[%0d]", s), rspRdata[s], 32'd0);
      check32($sformatf("reset_addr_err[%0d]", s), 32'(addrErr[s]), 32'd0);
      check32($sformatf("reset_acc_count[%0d]", s), accCount[s], 32'd0);
    end
    @(posedge clk); #1;

    // Store then load, latency 2.
    access(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    idleCycles(1);
    check32("acc_count_after_two", accCount[0], 32'd2);

    // Zero latency: store, then two back-to-back loads.
    access(1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0);
    idleCycles(1);
    access(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    access(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    idleCycles(1);

    // Address wrap: 0x400 aliases word 0.
    access(0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0);
    access(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    check32("wrap_model", modelMem[0][0], 32'h1234_5678);

    // Read-after-write with inputs perturbed during WAIT/DONE.
    access(0, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 1'b1);
    access(0, 1'b0, 32'h0000_0044, 32'h0, 1'b1);

    // Reset mid-WAIT and on the DONE-entry edge.
    access(0, 1'b1, 32'h0000_0008, 32'hAAAA_0000, 1'b0);
    abortStore(0, 32'h0000_0008, 32'h0000_0011, 1);
    access(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    abortStore(0, 32'h0000_0008, 32'h0000_0022, 2);
    access(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    abortStore(1, 32'h0000_0010, 32'h0000_0033, 0);
    access(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

    // Misaligned load reports addr_err and returns the containing word.
    access(0, 1'b0, 32'h0000_0042, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);

    // Randomized traffic over a small aliased pool of words.
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel   = int'($urandom_range(0, 1));
      rAddr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
      access(sel, 1'($urandom), rAddr, $urandom, (sel == 0) ? 1'($urandom) : 1'b0);
      idleCycles(int'($urandom_range(0, 2)));
    end
    idleCycles(1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
